// File: rtl/ro_freq_counter_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency counter.
package ro_freq_counter_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int WIN_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        FIN     = 2'd3
    } state_t;

endpackage

// File: rtl/ro_sync_edge.sv
// Two-flop synchronizer for the asynchronous RO input plus a rising-edge pulse.
module ro_sync_edge (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic RISE
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= D;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign RISE = sync & ~sync_d;

endmodule

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: settles the oscillator, then counts RO
// edges over a programmable window of CLK cycles.
//
//   state   | meaning
//   IDLE    | waiting for START, RO disabled, last result held
//   SETTLE  | RO enabled, SETTLE_CYC cycles for the oscillator to stabilise
//   MEASURE | RO enabled, counting edges for WIN_LEN cycles
//   FIN     | one cycle, DONE pulse, RO disabled
module ro_freq_counter
    import ro_freq_counter_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic             RO_IN,
    output logic             RO_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    // One down-counter times both phases, so it must hold the wider of the two.
    localparam int TMR_W = (WIN_W > 8) ? WIN_W : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [TMR_W-1:0]   tmr;
    logic [WIN_W-1:0]   win_q;
    logic               rise;

    ro_sync_edge u_sync (
        .CLK  (CLK),
        .RST  (RST),
        .D    (RO_IN),
        .RISE (rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            tmr   <= '0;
            win_q <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
            RO_EN <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= SETTLE;
                        win_q <= WIN_LEN;
                        tmr   <= TMR_W'(SETTLE_CYC - 1);
                        COUNT <= '0;
                        OVF   <= 1'b0;
                        RO_EN <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (ABORT) begin
                        state <= IDLE;
                        COUNT <= '0;
                        OVF   <= 1'b0;
                        RO_EN <= 1'b0;
                        BUSY  <= 1'b0;
                    end else if (tmr == '0) begin
                        if (win_q == '0) begin
                            state <= FIN;
                            RO_EN <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= MEASURE;
                            tmr   <= TMR_W'(win_q) - TMR_W'(1);
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                MEASURE: begin
                    if (ABORT) begin
                        state <= IDLE;
                        COUNT <= '0;
                        OVF   <= 1'b0;
                        RO_EN <= 1'b0;
                        BUSY  <= 1'b0;
                    end else begin
                        if (rise) begin
                            if (COUNT == CNT_MAX) begin
                                OVF <= 1'b1;
                            end else begin
                                COUNT <= COUNT + CNT_W'(1);
                            end
                        end
                        if (tmr == '0) begin
                            state <= FIN;
                            RO_EN <= 1'b0;
                            DONE  <= 1'b1;
                        end else begin
                            tmr <= tmr - TMR_W'(1);
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    RO_EN <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
